pong_engine: RTL and testbench

Parametrised two-player pong game core clocked on the VGA pixel clock. It owns ball and paddle kinematics, a serve/play/point/game-over state machine, and the scoring. It also answers per-pixel "which object is here" queries with one-cycle latency, so the colour mux downstream only selects between background and object colour. The block replaces the ad-hoc game logic that currently sits inside the VGA controller.

---
 rtl/pong_engine.sv | 215 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Two-player pong core: tick-paced ball/paddle kinematics, serve/play/point FSM,
// scoring, and a registered per-pixel object query for the colour mux.
module pong_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int CW          = 10,
    parameter int PAD_L_X     = 8,
    parameter int PAD_R_X     = 628,
    parameter int PAD_W       = 3,
    parameter int PAD_HALF    = 30,
    parameter int BALL_R      = 3,
    parameter int TICK_DIV    = 100000,
    parameter int SERVE_TICKS = 60,
    parameter int SW          = 3,
    parameter int WIN_SCORE   = 7
) (
    input  logic          iVGA_CLK,
    input  logic          iRST_n,
    input  logic          iSTART,
    input  logic          iUP_1,
    input  logic          iDN_1,
    input  logic          iUP_2,
    input  logic          iDN_2,
    input  logic [CW-1:0] iPX,
    input  logic [CW-1:0] iPY,
    output logic [CW-1:0] oBALL_X,
    output logic [CW-1:0] oBALL_Y,
    output logic [CW-1:0] oPAD1_Y,
    output logic [CW-1:0] oPAD2_Y,
    output logic [SW-1:0] oSCORE_1,
    output logic [SW-1:0] oSCORE_2,
    output logic [1:0]    oSTATE,
    output logic [1:0]    oOBJ_ID
);
    localparam int DW  = $clog2(TICK_DIV);
    localparam int SCW = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0] X_MID   = CW'(H_RES / 2);
    localparam logic [CW-1:0] Y_MID   = CW'(V_RES / 2);
    localparam logic [CW-1:0] X_LAST  = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(V_RES - 1);
    localparam logic [CW-1:0] PAD_MIN = CW'(PAD_HALF);
    localparam logic [CW-1:0] PAD_MAX = CW'(V_RES - 1 - PAD_HALF);
    localparam logic [CW-1:0] HIT_L_X = CW'(PAD_L_X + PAD_W);
    localparam logic [CW-1:0] HIT_R_X = CW'(PAD_R_X - 1);
    localparam logic [1:0] DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DN = 2'd2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

    state_t             r_state;
    logic [DW-1:0]      r_div;
    logic [SCW-1:0]     r_serve;
    logic [CW-1:0]      r_bx, r_by;
    logic               r_vx_neg;
    logic signed [1:0]  r_vy;
    logic [SW-1:0]      r_score1, r_score2;
    logic [1:0]         r_obj;

    logic               w_tick;
    logic [1:0]         w_up, w_dn, w_ball_near, w_obj_pad;
    logic [CW-1:0]      w_pad [2];
    logic [1:0]         w_dir [2];

    assign w_tick = (r_div == DW'(TICK_DIV - 1));
    assign w_up   = {iUP_2, iUP_1};
    assign w_dn   = {iDN_2, iDN_1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pad
            localparam int PX = (gi == 0) ? PAD_L_X : PAD_R_X;
            logic [CW-1:0] r_pad;
            logic [1:0]    r_dir;

            // Up wins over down; a press blocked by the clamp records no motion.
            always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
                if (!iRST_n) begin
                    r_pad <= Y_MID;
                    r_dir <= DIR_NONE;
                end else if (w_tick && r_state != S_OVER) begin
                    if (w_up[gi] && r_pad > PAD_MIN) begin
                        r_pad <= r_pad - 1'b1;
                        r_dir <= DIR_UP;
                    end else if (!w_up[gi] && w_dn[gi] && r_pad < PAD_MAX) begin
                        r_pad <= r_pad + 1'b1;
                        r_dir <= DIR_DN;
                    end else begin
                        r_dir <= DIR_NONE;
                    end
                end
            end

            assign w_pad[gi] = r_pad;
            assign w_dir[gi] = r_dir;
            assign w_ball_near[gi] = ({1'b0, r_by} + (CW+1)'(PAD_HALF) >= {1'b0, r_pad}) &&
                                     ({1'b0, r_pad} + (CW+1)'(PAD_HALF) >= {1'b0, r_by});
            assign w_obj_pad[gi] = (iPX >= CW'(PX)) && (iPX <= CW'(PX + PAD_W - 1)) &&
                                   ({1'b0, iPY} + (CW+1)'(PAD_HALF) >= {1'b0, r_pad}) &&
                                   ({1'b0, r_pad} + (CW+1)'(PAD_HALF) >= {1'b0, iPY});
        end
    endgenerate

    logic              w_hit_l, w_hit_r, w_vx_neg_n, w_obj_ball;
    logic signed [1:0] w_vy_n;
    logic [CW-1:0]     w_bx_n, w_by_n;
    logic [SW-1:0]     w_score1_inc, w_score2_inc;

    assign w_hit_l = r_vx_neg && (r_bx == HIT_L_X) && w_ball_near[0];
    assign w_hit_r = !r_vx_neg && (r_bx == HIT_R_X) && w_ball_near[1];
    assign w_score1_inc = r_score1 + 1'b1;
    assign w_score2_inc = r_score2 + 1'b1;

    // Paddle reflection first, then the wall sees the already-updated vy.
    always_comb begin
        w_vx_neg_n = r_vx_neg;
        w_vy_n     = r_vy;
        if (w_hit_l) begin
            w_vx_neg_n = 1'b0;
            if (w_dir[0] == DIR_UP)      w_vy_n = -2'sd1;
            else if (w_dir[0] == DIR_DN) w_vy_n = 2'sd1;
        end
        if (w_hit_r) begin
            w_vx_neg_n = 1'b1;
            if (w_dir[1] == DIR_UP)      w_vy_n = -2'sd1;
            else if (w_dir[1] == DIR_DN) w_vy_n = 2'sd1;
        end
        if (r_by == '0 && w_vy_n == -2'sd1)        w_vy_n = 2'sd1;
        else if (r_by == Y_LAST && w_vy_n == 2'sd1) w_vy_n = -2'sd1;
        w_bx_n = w_vx_neg_n ? r_bx - 1'b1 : r_bx + 1'b1;
        w_by_n = r_by;
        if (w_vy_n == 2'sd1)       w_by_n = r_by + 1'b1;
        else if (w_vy_n == -2'sd1) w_by_n = r_by - 1'b1;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_serve  <= '0;
            r_bx     <= X_MID;
            r_by     <= Y_MID;
            r_vx_neg <= 1'b1;
            r_vy     <= 2'sd0;
            r_score1 <= '0;
            r_score2 <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (iSTART) begin
                        r_state  <= S_SERVE;
                        r_serve  <= '0;
                        r_score1 <= '0;
                        r_score2 <= '0;
                    end
                end
                S_SERVE: begin
                    if (w_tick) begin
                        if (r_serve == SCW'(SERVE_TICKS - 1)) begin
                            r_serve <= SCW'(SERVE_TICKS);
                            r_state <= S_PLAY;
                        end else begin
                            r_serve <= r_serve + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        if (r_bx == '0 || r_bx == X_LAST) begin
                            r_bx     <= X_MID;
                            r_by     <= Y_MID;
                            r_vy     <= 2'sd0;
                            r_serve  <= '0;
                            r_vx_neg <= (r_bx != '0);
                            if (r_bx == '0) begin
                                r_score2 <= w_score2_inc;
                                r_state  <= (w_score2_inc == SW'(WIN_SCORE)) ? S_OVER : S_SERVE;
                            end else begin
                                r_score1 <= w_score1_inc;
                                r_state  <= (w_score1_inc == SW'(WIN_SCORE)) ? S_OVER : S_SERVE;
                            end
                        end else begin
                            r_bx     <= w_bx_n;
                            r_by     <= w_by_n;
                            r_vx_neg <= w_vx_neg_n;
                            r_vy     <= w_vy_n;
                        end
                    end
                end
            endcase
        end
    end

    // Widened sums keep the region test free of underflow near the edges.
    assign w_obj_ball = ({1'b0, iPX} + (CW+1)'(BALL_R) >= {1'b0, r_bx}) &&
                        ({1'b0, r_bx} + (CW+1)'(BALL_R) >= {1'b0, iPX}) &&
                        ({1'b0, iPY} + (CW+1)'(BALL_R) >= {1'b0, r_by}) &&
                        ({1'b0, r_by} + (CW+1)'(BALL_R) >= {1'b0, iPY});

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)           r_obj <= 2'd0;
        else if (w_obj_ball)   r_obj <= 2'd3;
        else if (w_obj_pad[0]) r_obj <= 2'd1;
        else if (w_obj_pad[1]) r_obj <= 2'd2;
        else                   r_obj <= 2'd0;
    end

    assign oBALL_X  = r_bx;
    assign oBALL_Y  = r_by;
    assign oPAD1_Y  = w_pad[0];
    assign oPAD2_Y  = w_pad[1];
    assign oSCORE_1 = r_score1;
    assign oSCORE_2 = r_score2;
    assign oSTATE   = r_state;
    assign oOBJ_ID  = r_obj;
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed game scenarios plus randomized play, all checked
// against a tick-level behavioural model of the game rules.
module tb_pong_engine;
    localparam int H = 64, V = 48, CW = 10, PLX = 2, PRX = 60, PW = 2, PH = 4;
    localparam int BR = 1, TD = 4, ST = 3, SW = 3, WIN = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic up1 = 1'b0, dn1 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
    logic [CW-1:0] px = '0, py = '0;
    logic [CW-1:0] ball_x, ball_y, pad1_y, pad2_y;
    logic [SW-1:0] score_1, score_2;
    logic [1:0]    state, obj_id;

    always #5 clk = ~clk;

    pong_engine #(
        .H_RES(H), .V_RES(V), .CW(CW), .PAD_L_X(PLX), .PAD_R_X(PRX), .PAD_W(PW),
        .PAD_HALF(PH), .BALL_R(BR), .TICK_DIV(TD), .SERVE_TICKS(ST), .SW(SW), .WIN_SCORE(WIN)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iSTART(start),
        .iUP_1(up1), .iDN_1(dn1), .iUP_2(up2), .iDN_2(dn2),
        .iPX(px), .iPY(py),
        .oBALL_X(ball_x), .oBALL_Y(ball_y), .oPAD1_Y(pad1_y), .oPAD2_Y(pad2_y),
        .oSCORE_1(score_1), .oSCORE_2(score_2), .oSTATE(state), .oOBJ_ID(obj_id)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check_val(input string tag, input integer act, input integer exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Game model: plain integer positions and signed velocities
    int m_bx, m_by, m_vx, m_vy, m_state, m_serve, m_div, m_obj;
    int m_p[2], m_d[2], m_s[2];

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int model_query(input int qx, input int qy);
        if (iabs(qx - m_bx) <= BR && iabs(qy - m_by) <= BR) return 3;
        if (qx >= PLX && qx < PLX + PW && iabs(qy - m_p[0]) <= PH) return 1;
        if (qx >= PRX && qx < PRX + PW && iabs(qy - m_p[1]) <= PH) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_bx = H / 2; m_by = V / 2; m_vx = -1; m_vy = 0;
        m_state = 0; m_serve = 0; m_div = 0; m_obj = 0;
        m_p = '{V / 2, V / 2}; m_d = '{0, 0}; m_s = '{0, 0};
    endtask

    task automatic model_step();
        bit tick;
        int op[2], od[2];
        int want, vx, vy, w;
        tick  = (m_div == TD - 1);
        m_obj = model_query(int'(px), int'(py));
        m_div = (m_div + 1) % TD;
        op = m_p; od = m_d;
        if (tick && m_state != 3) begin
            for (int i = 0; i < 2; i++) begin
                if ((i == 0) ? up1 : up2)      want = -1;
                else if ((i == 0) ? dn1 : dn2) want = 1;
                else                           want = 0;
                if (m_p[i] + want < PH || m_p[i] + want > V - 1 - PH) want = 0;
                m_p[i] += want;
                m_d[i] = want;
            end
        end
        case (m_state)
            0, 3: if (start) begin m_state = 1; m_serve = 0; m_s = '{0, 0}; end
            1: if (tick) begin
                m_serve++;
                if (m_serve == ST) m_state = 2;
            end
            2: if (tick) begin
                if (m_bx == 0 || m_bx == H - 1) begin
                    w = (m_bx == 0) ? 1 : 0;
                    m_s[w]++;
                    m_bx = H / 2; m_by = V / 2; m_vy = 0;
                    m_vx = (w == 1) ? 1 : -1;
                    m_serve = 0;
                    m_state = (m_s[w] == WIN) ? 3 : 1;
                end else begin
                    vx = m_vx; vy = m_vy;
                    if (m_vx == -1 && m_bx == PLX + PW && iabs(m_by - op[0]) <= PH) begin
                        vx = 1;
                        if (od[0] != 0) vy = od[0];
                    end
                    if (m_vx == 1 && m_bx == PRX - 1 && iabs(m_by - op[1]) <= PH) begin
                        vx = -1;
                        if (od[1] != 0) vy = od[1];
                    end
                    if (m_by == 0 && vy == -1)          vy = 1;
                    else if (m_by == V - 1 && vy == 1)  vy = -1;
                    m_vx = vx; m_vy = vy;
                    m_bx += vx; m_by += vy;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check_val("state",   state,   m_state);
        check_val("ball_x",  ball_x,  m_bx);
        check_val("ball_y",  ball_y,  m_by);
        check_val("pad1_y",  pad1_y,  m_p[0]);
        check_val("pad2_y",  pad2_y,  m_p[1]);
        check_val("score_1", score_1, m_s[0]);
        check_val("score_2", score_2, m_s[1]);
        check_val("obj_id",  obj_id,  m_obj);
    endtask

    int prev_state = 0;

    task automatic step_cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        compare_all();
        if (m_state != prev_state)
            $display("t=%0t state %0d->%0d score %0d-%0d ball (%0d,%0d)",
                     $time, prev_state, m_state, m_s[0], m_s[1], m_bx, m_by);
        prev_state = m_state;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"}, state, 0);
        check_val({tag, "_bx"}, ball_x, H / 2);
        check_val({tag, "_by"}, ball_y, V / 2);
        check_val({tag, "_pad1"}, pad1_y, V / 2);
        check_val({tag, "_pad2"}, pad2_y, V / 2);
        check_val({tag, "_s1"}, score_1, 0);
        check_val({tag, "_s2"}, score_2, 0);
        check_val({tag, "_obj"}, obj_id, 0);
    endtask

    initial begin
        int qx[5], qy[5], qe[5];
        int pv, t, budget;
        bit done;
        qx = '{32, 33, 2, 61, 10};
        qy = '{24, 25, 24, 20, 10};
        qe = '{3, 3, 1, 2, 0};

        model_reset();
        repeat (2) step_cycle();
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            px = CW'(qx[i]); py = CW'(qy[i]);
            step_cycle();
            check_val("query_fixed", obj_id, qe[i]);
        end

        up1 = 1'b1;
        repeat (25 * TD) step_cycle();
        check_val("pad1_clamp_top", pad1_y, PH);
        up1 = 1'b0;

        start = 1'b1;
        step_cycle();
        check_val("serve_entry", state, 1);
        start = 1'b0;

        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin step_cycle(); done = (m_s[1] == 1); end
        check_val("first_miss_s2", score_2, 1);
        check_val("first_miss_bx", ball_x, H / 2);
        check_val("first_miss_state", state, 1);

        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin step_cycle(); done = (m_state == 3); end
        check_val("game_over_state", state, 3);
        check_val("game_over_s2", score_2, WIN);

        dn1 = 1'b1; up2 = 1'b1;
        repeat (10 * TD) step_cycle();
        check_val("over_pad1_frozen", pad1_y, PH);
        check_val("over_pad2_frozen", pad2_y, V / 2);
        dn1 = 1'b0; up2 = 1'b0;

        start = 1'b1;
        step_cycle();
        start = 1'b0;
        check_val("restart_state", state, 1);
        check_val("restart_s2", score_2, 0);

        dn1 = 1'b1;
        repeat (20 * TD) step_cycle();
        dn1 = 1'b0;
        check_val("pad1_centred", pad1_y, V / 2);

        // Stationary paddle return: vy stays 0
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            pv = m_vx; step_cycle();
            done = (pv == -1 && m_vx == 1);
        end
        check_val("hit_still_bx", ball_x, PLX + PW + 1);
        check_val("hit_still_by", ball_y, V / 2);

        // Paddle moving down at impact: ball picks up vy=+1
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            dn1 = (m_vx == -1 && m_bx <= PLX + PW + 2);
            pv = m_vx; step_cycle();
            done = (pv == -1 && m_vx == 1);
        end
        dn1 = 1'b0;
        check_val("hit_down_bx", ball_x, PLX + PW + 1);
        check_val("hit_down_by", ball_y, V / 2 + 1);

        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 63) == 0) {up1, dn1, up2, dn2} = 4'($urandom);
            start = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: begin px = CW'($urandom_range(0, 1023)); py = CW'($urandom_range(0, 1023)); end
                1: begin px = CW'($urandom_range(0, H - 1)); py = CW'($urandom_range(0, V - 1)); end
                default: begin
                    t = m_bx + int'($urandom_range(0, 4)) - 2; px = CW'((t < 0) ? 0 : t);
                    t = m_by + int'($urandom_range(0, 4)) - 2; py = CW'((t < 0) ? 0 : t);
                end
            endcase
            step_cycle();
        end

        done = 0;
        budget = 4000;
        for (int c = 0; c < budget && !done; c++) begin
            start = (m_state == 3 || m_state == 0);
            step_cycle();
            done = (m_state == 2);
        end
        start = 1'b0;
        check_val("reach_play", state, 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        prev_state = 0;
        step_cycle();
        rst_n = 1'b1;
        repeat (8) step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
